// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-3 registered word router.
package demux_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEST_W        = 2;
    localparam int unsigned NUM_OUT       = 3;
    localparam int unsigned CNT_W         = 16;

    localparam logic [DEST_W-1:0] DEST_OUT0 = 2'd0;
    localparam logic [DEST_W-1:0] DEST_OUT1 = 2'd1;
    localparam logic [DEST_W-1:0] DEST_OUT2 = 2'd2;
    localparam logic [DEST_W-1:0] DEST_DROP = 2'd3;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot with load/take handshake and pass-through refill.
module demux_slot
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             take,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    slot_state_t state;
    slot_state_t state_next;

    // Slot occupancy register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next occupancy; a take with a simultaneous load keeps the slot full.
    always_comb begin
        state_next = state;
        case (state)
            SLOT_EMPTY: if (load)          state_next = SLOT_FULL;
            SLOT_FULL:  if (take && !load) state_next = SLOT_EMPTY;
            default:                       state_next = SLOT_EMPTY;
        endcase
    end

    // Data register only changes when a word is written in.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end
    end

    assign full = (state == SLOT_FULL);

endmodule

// File: rtl/demux3_route16b.sv
// Registered 1-to-3 word router with per-destination holding slots.
// Optional feature: define DEMUX_DROP_COUNT_EN to add the saturating
// drop_count port counting words accepted with destination 3.
module demux3_route16b
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [DEST_W-1:0]    in_dest,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data0,
    output logic [WIDTH-1:0]     out_data1,
    output logic [WIDTH-1:0]     out_data2,
    output logic [NUM_OUT-1:0]   out_valid,
    input  logic [NUM_OUT-1:0]   out_ready
`ifdef DEMUX_DROP_COUNT_EN
    ,
    output logic [CNT_W-1:0]     drop_count
`endif
);

    logic               accept;
    logic [NUM_OUT-1:0] load;

    // Ready when the target slot is free or draining this cycle; drops always accepted.
    always_comb begin
        in_ready = 1'b1;
        case (in_dest)
            DEST_OUT0: in_ready = !out_valid[0] || out_ready[0];
            DEST_OUT1: in_ready = !out_valid[1] || out_ready[1];
            DEST_OUT2: in_ready = !out_valid[2] || out_ready[2];
            default:   in_ready = 1'b1;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Destination decode into per-slot load strobes.
    always_comb begin
        load    = '0;
        load[0] = accept && (in_dest == DEST_OUT0);
        load[1] = accept && (in_dest == DEST_OUT1);
        load[2] = accept && (in_dest == DEST_OUT2);
    end

    demux_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (load[0]),
        .load_data (in_data),
        .take      (out_ready[0]),
        .full      (out_valid[0]),
        .data      (out_data0)
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (load[1]),
        .load_data (in_data),
        .take      (out_ready[1]),
        .full      (out_valid[1]),
        .data      (out_data1)
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot2 (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (load[2]),
        .load_data (in_data),
        .take      (out_ready[2]),
        .full      (out_valid[2]),
        .data      (out_data2)
    );

`ifdef DEMUX_DROP_COUNT_EN
    // Saturating count of discarded words.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (accept && (in_dest == DEST_DROP) && (drop_count != '1)) begin
            drop_count <= drop_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_demux3_route16b.sv
// Directed self-checking bench for demux3_route16b.
// Define DEMUX_DROP_COUNT_EN on both RTL and bench to cover drop_count.
module tb_demux3_route16b;

    logic        clock;
    logic        reset_n;
    logic [15:0] in_data;
    logic [1:0]  in_dest;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data0;
    logic [15:0] out_data1;
    logic [15:0] out_data2;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
`ifdef DEMUX_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    int n_tests;
    int n_fail;
    int xfer1;

    demux3_route16b dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data0  (out_data0),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef DEMUX_DROP_COUNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count completed transfers on output 1.
    always @(posedge clock) begin
        if (reset_n && out_valid[1] && out_ready[1]) xfer1 = xfer1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge, to a point safe for driving inputs.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] dst);
        in_valid = v;
        in_data  = d;
        in_dest  = dst;
    endtask

    int snap;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        xfer1     = 0;
        reset_n   = 1'b0;
        in_data   = '0;
        in_dest   = '0;
        in_valid  = 1'b0;
        out_ready = 3'b000;

        // Reset state.
        mid();
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data0", 32'(out_data0), 32'h0);
        check("rst_data1", 32'(out_data1), 32'h0);
        check("rst_data2", 32'(out_data2), 32'h0);
        check("rst_ready", 32'(in_ready), 32'h1);
`ifdef DEMUX_DROP_COUNT_EN
        check("rst_drop", 32'(drop_count), 32'h0);
`endif
        step();
        mid();
        reset_n = 1'b1;
        step();

        // Basic routing, back-to-back, all consumers ready.
        out_ready = 3'b111;
        drive(1'b1, 16'hA001, 2'd0);
        mid();
        check("basic_rdy0", 32'(in_ready), 32'h1);
        step();
        drive(1'b1, 16'hB002, 2'd1);
        mid();
        check("basic_v0", 32'(out_valid), 32'h1);
        check("basic_d0", 32'(out_data0), 32'hA001);
        check("basic_rdy1", 32'(in_ready), 32'h1);
        step();
        drive(1'b1, 16'hC003, 2'd2);
        mid();
        check("basic_v1", 32'(out_valid), 32'h2);
        check("basic_d1", 32'(out_data1), 32'hB002);
        check("basic_rdy2", 32'(in_ready), 32'h1);
        step();
        drive(1'b0, 16'h0000, 2'd0);
        mid();
        check("basic_v2", 32'(out_valid), 32'h4);
        check("basic_d2", 32'(out_data2), 32'hC003);
        check("basic_hold0", 32'(out_data0), 32'hA001);
        step();
        mid();
        check("basic_empty", 32'(out_valid), 32'h0);
        step();

        // Backpressure on output 0.
        out_ready = 3'b110;
        drive(1'b1, 16'h1111, 2'd0);
        mid();
        check("bp_rdy_first", 32'(in_ready), 32'h1);
        step();
        drive(1'b1, 16'h2222, 2'd0);
        mid();
        check("bp_v0", 32'(out_valid[0]), 32'h1);
        check("bp_d0", 32'(out_data0), 32'h1111);
        check("bp_stall", 32'(in_ready), 32'h0);
        step();
        mid();
        check("bp_stall2", 32'(in_ready), 32'h0);
        check("bp_d0_hold", 32'(out_data0), 32'h1111);
        check("bp_v0_hold", 32'(out_valid[0]), 32'h1);
        step();
        out_ready = 3'b111;
        mid();
        check("bp_release_rdy", 32'(in_ready), 32'h1);
        step();
        drive(1'b0, 16'h0000, 2'd0);
        mid();
        check("bp_refill_v0", 32'(out_valid[0]), 32'h1);
        check("bp_refill_d0", 32'(out_data0), 32'h2222);
        step();
        mid();
        check("bp_drained", 32'(out_valid), 32'h0);
        step();

        // Concurrent drain and refill on output 1.
        out_ready = 3'b000;
        drive(1'b1, 16'h5555, 2'd1);
        step();
        snap = xfer1;
        out_ready = 3'b010;
        drive(1'b1, 16'h6666, 2'd1);
        mid();
        check("cd_d1_first", 32'(out_data1), 32'h5555);
        check("cd_rdy", 32'(in_ready), 32'h1);
        step();
        drive(1'b0, 16'h0000, 2'd0);
        mid();
        check("cd_v1", 32'(out_valid[1]), 32'h1);
        check("cd_d1", 32'(out_data1), 32'h6666);
        step();
        out_ready = 3'b000;
        mid();
        check("cd_empty", 32'(out_valid), 32'h0);
        check("cd_xfers", 32'(xfer1 - snap), 32'h2);
        step();

        // Drops: accepted, no slot changes.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h7770 + 16'(i), 2'd3);
            mid();
            check("drop_rdy", 32'(in_ready), 32'h1);
            step();
        end
        drive(1'b0, 16'h0000, 2'd0);
        mid();
        check("drop_valid", 32'(out_valid), 32'h0);
        check("drop_d0", 32'(out_data0), 32'h2222);
        check("drop_d1", 32'(out_data1), 32'h6666);
        check("drop_d2", 32'(out_data2), 32'hC003);
`ifdef DEMUX_DROP_COUNT_EN
        check("drop_cnt3", 32'(drop_count), 32'h3);
        step();
        drive(1'b1, 16'h0BAD, 2'd3);
        for (int i = 0; i < 65532; i++) step();
        drive(1'b0, 16'h0000, 2'd0);
        mid();
        check("drop_cnt_max", 32'(drop_count), 32'hFFFF);
        step();
        drive(1'b1, 16'h0BAD, 2'd3);
        for (int i = 0; i < 3; i++) step();
        drive(1'b0, 16'h0000, 2'd0);
        mid();
        check("drop_cnt_sat", 32'(drop_count), 32'hFFFF);
`endif
        step();

        // Fill all slots, then reset mid-stream.
        out_ready = 3'b000;
        drive(1'b1, 16'hAAAA, 2'd0);
        step();
        drive(1'b1, 16'hBBBB, 2'd1);
        step();
        drive(1'b1, 16'hCCCC, 2'd2);
        step();
        drive(1'b1, 16'hDDDD, 2'd0);
        mid();
        check("full_valid", 32'(out_valid), 32'h7);
        check("full_stall", 32'(in_ready), 32'h0);
        in_dest = 2'd3;
        #1;
        check("full_drop_rdy", 32'(in_ready), 32'h1);
        in_dest = 2'd0;
        step();
        #1;
        reset_n = 1'b0;
        #1;
        check("mrst_valid", 32'(out_valid), 32'h0);
        check("mrst_d0", 32'(out_data0), 32'h0);
        check("mrst_d1", 32'(out_data1), 32'h0);
        check("mrst_d2", 32'(out_data2), 32'h0);
`ifdef DEMUX_DROP_COUNT_EN
        check("mrst_drop", 32'(drop_count), 32'h0);
`endif
        drive(1'b0, 16'h0000, 2'd0);
        step();
        mid();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_dest = 2'(k);
            #1;
            check("post_rst_rdy", 32'(in_ready), 32'h1);
        end
        step();
        mid();
        check("post_rst_valid", 32'(out_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
